multicycle_ctrl: RTL

- Moore FSM controller that sequences the shared multi-cycle MIPS datapath: a single ALU, a single unified memory, the IR, the register bank and the PC.
- Decodes opcode/func, drives the per-state datapath strobes, waits on a memory ready handshake, and computes the PC enable from Zero.
- Supports R-type (ADD/SUB/AND/OR/SLT), LW, SW, BEQ and J.

---
 rtl/multicycle_ctrl.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Moore controller for the shared multi-cycle MIPS datapath (R-type, LW, SW, BEQ, J).
// Optional retired-instruction counter is enabled by defining RETIRE_CNT_EN.
module multicycle_ctrl #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             regdst,
  output logic             mem2reg,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic             extop,
  output logic [3:0]       aluop,
  output logic [1:0]       pcsource,
  output logic             retire,
  output logic             err,
`ifdef RETIRE_CNT_EN
  output logic [CNT_W-1:0] retired_cnt,
`endif
  output logic [3:0]       state_o
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_RWB    = 4'd4,
    S_MEMADR = 4'd5,
    S_MEMRD  = 4'd6,
    S_MEMWB  = 4'd7,
    S_MEMWR  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ERR    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_INV = 4'b1111;

  localparam logic [7:0] WaitMax = 8'(WAIT_MAX);

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       stall_state;
  logic       timeout;
  logic       func_ok;
  logic       pc_write;
  logic       pc_write_cond;

  assign stall_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign timeout     = (wait_q == WaitMax);
  assign func_ok     = (func == FN_ADD) || (func == FN_SUB) || (func == FN_AND) ||
                       (func == FN_OR)  || (func == FN_SLT);

  // Any cycle outside a stalled access clears the counter, so entry into a wait state starts at 0.
  assign wait_d = (stall_state && !mem_ready) ? wait_q + 8'd1 : 8'd0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
                else if (timeout) state_d = S_ERR;
      S_DECODE: begin
        if (opcode == OP_RTYPE)                        state_d = func_ok ? S_EXEC : S_ERR;
        else if (opcode == OP_LW || opcode == OP_SW)   state_d = S_MEMADR;
        else if (opcode == OP_BEQ)                     state_d = S_BRANCH;
        else if (opcode == OP_J)                       state_d = S_JUMP;
        else                                           state_d = S_ERR;
      end
      S_EXEC:   state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
                else if (timeout) state_d = S_ERR;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
                else if (timeout) state_d = S_ERR;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Strobes decode from the current state; only FETCH/MEMWR look at mem_ready and BRANCH at zero.
  always_comb begin
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    regdst        = 1'b0;
    mem2reg       = 1'b0;
    regwrite      = 1'b0;
    alusrca       = 1'b0;
    alusrcb       = 2'b00;
    extop         = 1'b0;
    aluop         = ALU_INV;
    pcsource      = 2'b00;
    retire        = 1'b0;
    err           = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        alusrcb  = 2'b01;
        aluop    = ALU_ADD;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        extop   = 1'b1;
        aluop   = ALU_ADD;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        unique case (func)
          FN_ADD:  aluop = ALU_ADD;
          FN_SUB:  aluop = ALU_SUB;
          FN_AND:  aluop = ALU_AND;
          FN_OR:   aluop = ALU_OR;
          FN_SLT:  aluop = ALU_SLT;
          default: aluop = ALU_INV;
        endcase
      end
      S_RWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        retire   = 1'b1;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        extop   = 1'b1;
        aluop   = ALU_ADD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        mem2reg  = 1'b1;
        regwrite = 1'b1;
        retire   = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        retire    = mem_ready;
      end
      S_BRANCH: begin
        alusrca       = 1'b1;
        aluop         = ALU_SUB;
        pc_write_cond = 1'b1;
        pcsource      = 2'b01;
        retire        = 1'b1;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pcsource = 2'b10;
        retire   = 1'b1;
      end
      S_ERR:   err = 1'b1;
      default: ;
    endcase
  end

  assign pc_en   = pc_write | (pc_write_cond & zero);
  assign state_o = state_q;

`ifdef RETIRE_CNT_EN
  logic [CNT_W-1:0] retired_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_cnt_q <= '0;
    end else if (retire && state_q != S_ERR) begin
      retired_cnt_q <= retired_cnt_q + 1'b1;
    end
  end

  assign retired_cnt = retired_cnt_q;
`endif

endmodule
